// File: rtl/pfm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pfm_pkg                                                         |
// | Purpose  : Shared types and constants for the pass/fail status monitor:    |
// |            FSM state encoding, failure-reason codes, default counter width.|
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pfm_pkg;

  // Monitor state; PASS and FAIL are terminal until reset.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } pfm_state_e;

  // Reason reported on fail_code_o.
  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_MISMATCH  = 2'd1,
    FC_TIMEOUT   = 2'd2,
    FC_UNDERRUN  = 2'd3
  } pfm_fail_code_e;

  // Counter width matching the simulation top's cycle counter.
  localparam int unsigned C_CNT_W_DEFAULT = 16;

endpackage : pfm_pkg
`default_nettype wire

// File: rtl/pfm_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pfm_sat_counter                                                 |
// | Purpose  : Up-counter that sticks at all-ones, with clear and freeze.      |
// | Ports    : clk, reset    - clock, asynchronous active-high reset           |
// |            clear_i       - force count to zero (highest priority)          |
// |            freeze_i      - hold the current value                          |
// |            inc_i         - add one unless saturated                        |
// |            count_o       - current count                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pfm_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             freeze_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!freeze_i && inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : pfm_sat_counter
`default_nettype wire

// File: rtl/pass_fail_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pass_fail_monitor                                               |
// | Purpose  : Collects masked compare events, counts checks/errors/run cycles,|
// |            and produces sticky passed/failed flags with a failure code.    |
// |            An internal watchdog fails the test after TIMEOUT_CYC RUN       |
// |            cycles so the failure is visible before the top's limit.        |
// | Ports    : clk, reset              - clock, async active-high reset        |
// |            start_i                 - begin test (IDLE -> RUN)              |
// |            chk_valid_i             - compare event this cycle              |
// |            chk_actual_i/expect_i   - observed / expected data              |
// |            chk_mask_i              - 1 = bit compared                      |
// |            done_i                  - stimulus complete                     |
// |            passed_o / failed_o     - sticky verdict                        |
// |            fail_code_o             - 0 none,1 mismatch,2 timeout,3 underrun|
// |            chk_cnt_o/err_cnt_o     - checks accepted / mismatches seen     |
// |            run_cyc_o               - cycles spent in RUN                   |
// | Option   : PFM_ERR_CAPTURE_EN adds err_actual_o, err_expect_o, err_cyc_o   |
// |            holding the data and run cycle of the first mismatch.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pass_fail_monitor
  import pfm_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MIN_CHECKS  = 1,
  parameter int unsigned TIMEOUT_CYC = 90,
  parameter int unsigned CNT_W       = C_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              chk_valid_i,
  input  logic [DATA_W-1:0] chk_actual_i,
  input  logic [DATA_W-1:0] chk_expect_i,
  input  logic [DATA_W-1:0] chk_mask_i,
  input  logic              done_i,
  output logic              passed_o,
  output logic              failed_o,
  output logic [1:0]        fail_code_o,
  output logic [CNT_W-1:0]  chk_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  run_cyc_o
`ifdef PFM_ERR_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] err_actual_o,
  output logic [DATA_W-1:0] err_expect_o,
  output logic [CNT_W-1:0]  err_cyc_o
`endif
);

  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W:0]   C_MIN_CHK_EXT  = (CNT_W+1)'(MIN_CHECKS);

  pfm_state_e     state_q, state_d;
  pfm_fail_code_e fail_code_q, fail_code_d;

  logic in_run;
  logic terminal;
  logic mism;
  logic timeout_hit;
  logic enough_checks;
  logic [CNT_W:0] checks_incl_now;

  assign in_run   = (state_q == ST_RUN);
  assign terminal = (state_q == ST_PASS) || (state_q == ST_FAIL);

  // A zero mask bit removes that bit from the compare; an all-zero mask
  // therefore always matches but the event is still counted.
  assign mism = chk_valid_i && (|((chk_actual_i ^ chk_expect_i) & chk_mask_i));

  assign timeout_hit = (run_cyc_o == C_TIMEOUT_LAST);

  // One extra bit so a saturated count plus this cycle's check cannot wrap.
  // Including chk_valid_i lets a check arriving with done count toward the floor.
  assign checks_incl_now = {1'b0, chk_cnt_o} + {{CNT_W{1'b0}}, chk_valid_i};
  assign enough_checks   = (checks_incl_now >= C_MIN_CHK_EXT);

  // ---------------------------------------------------------------------------
  // Counters: advance only in RUN, frozen once a verdict is reached.
  // ---------------------------------------------------------------------------
  logic cnt_clear;
  assign cnt_clear = (state_q == ST_IDLE) && start_i;

  pfm_sat_counter #(.WIDTH(CNT_W)) u_run_cyc (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .freeze_i (terminal),
    .inc_i    (in_run),
    .count_o  (run_cyc_o)
  );

  pfm_sat_counter #(.WIDTH(CNT_W)) u_chk_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .freeze_i (terminal),
    .inc_i    (in_run && chk_valid_i),
    .count_o  (chk_cnt_o)
  );

  pfm_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .freeze_i (terminal),
    .inc_i    (in_run && mism),
    .count_o  (err_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fail_code_q <= FC_NONE;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. RUN exits are prioritised mismatch > timeout > done.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mism) begin
          state_d     = ST_FAIL;
          fail_code_d = FC_MISMATCH;
        end else if (timeout_hit) begin
          state_d     = ST_FAIL;
          fail_code_d = FC_TIMEOUT;
        end else if (done_i) begin
          if (enough_checks) begin
            state_d = ST_PASS;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = FC_UNDERRUN;
          end
        end
      end
      default: begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state so they follow the deciding
  // cycle by one clock and can never both be high.
  // ---------------------------------------------------------------------------
  always_comb begin
    passed_o    = (state_q == ST_PASS);
    failed_o    = (state_q == ST_FAIL);
    fail_code_o = fail_code_q;
  end

`ifdef PFM_ERR_CAPTURE_EN
  // ---------------------------------------------------------------------------
  // First-mismatch capture. A mismatch in RUN always ends the run, so the
  // err_cnt==0 qualifier only makes "first" explicit.
  // ---------------------------------------------------------------------------
  logic              capture;
  logic [DATA_W-1:0] err_actual_q;
  logic [DATA_W-1:0] err_expect_q;
  logic [CNT_W-1:0]  err_cyc_q;

  assign capture = in_run && mism && (err_cnt_o == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_actual_q <= '0;
      err_expect_q <= '0;
      err_cyc_q    <= '0;
    end else if (capture) begin
      err_actual_q <= chk_actual_i;
      err_expect_q <= chk_expect_i;
      err_cyc_q    <= run_cyc_o;
    end
  end

  assign err_actual_o = err_actual_q;
  assign err_expect_o = err_expect_q;
  assign err_cyc_o    = err_cyc_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && capture) begin
      $display("pass_fail_monitor: first mismatch actual=0x%0h expect=0x%0h run_cyc=%0d",
               chk_actual_i, chk_expect_i, run_cyc_o);
    end
  end
`endif
`endif

endmodule : pass_fail_monitor
`default_nettype wire

// File: tb/tb_pass_fail_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pass_fail_monitor                                            |
// | Purpose  : Scoreboard bench for pass_fail_monitor. Two instances share     |
// |            stimulus: dut_a with MIN_CHECKS=1, dut_b with MIN_CHECKS=2.     |
// |            Expected verdicts are queued when the deciding input is driven; |
// |            monitors pop and compare when passed/failed rises.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pass_fail_monitor;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start_i, chk_valid_i, done_i;
  logic [DW-1:0] act_i, exp_i, mask_i;

  logic          pa, fa, pb, fb;
  logic [1:0]    codea, codeb;
  logic [CW-1:0] chka, erra, runa, chkb, errb, runb;
`ifdef PFM_ERR_CAPTURE_EN
  logic [DW-1:0] cap_act_a, cap_exp_a, cap_act_b, cap_exp_b;
  logic [CW-1:0] cap_cyc_a, cap_cyc_b;
`endif

  pass_fail_monitor #(.DATA_W(DW), .MIN_CHECKS(1), .TIMEOUT_CYC(90), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .start_i(start_i), .chk_valid_i(chk_valid_i),
    .chk_actual_i(act_i), .chk_expect_i(exp_i), .chk_mask_i(mask_i), .done_i(done_i),
    .passed_o(pa), .failed_o(fa), .fail_code_o(codea),
    .chk_cnt_o(chka), .err_cnt_o(erra), .run_cyc_o(runa)
`ifdef PFM_ERR_CAPTURE_EN
    , .err_actual_o(cap_act_a), .err_expect_o(cap_exp_a), .err_cyc_o(cap_cyc_a)
`endif
  );

  pass_fail_monitor #(.DATA_W(DW), .MIN_CHECKS(2), .TIMEOUT_CYC(90), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_i), .chk_valid_i(chk_valid_i),
    .chk_actual_i(act_i), .chk_expect_i(exp_i), .chk_mask_i(mask_i), .done_i(done_i),
    .passed_o(pb), .failed_o(fb), .fail_code_o(codeb),
    .chk_cnt_o(chkb), .err_cnt_o(errb), .run_cyc_o(runb)
`ifdef PFM_ERR_CAPTURE_EN
    , .err_actual_o(cap_act_b), .err_expect_o(cap_exp_b), .err_cyc_o(cap_cyc_b)
`endif
  );

  typedef struct {
    int p; int f; int code; int chk; int err; int run; int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input longint actual, input longint required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Expected verdict; visible at the negedge after the next posedge.
  function automatic exp_t mk(input int p, input int f, input int code,
                              input int chk, input int err, input int run);
    exp_t r;
    r.p = p; r.f = f; r.code = code; r.chk = chk; r.err = err; r.run = run;
    r.cyc = ncyc + 1;
    return r;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic p, input logic f,
                     input logic [1:0] code, input logic [CW-1:0] chk,
                     input logic [CW-1:0] err, input logic [CW-1:0] run);
    check({tag, "_passed"},  p,    e.p);
    check({tag, "_failed"},  f,    e.f);
    check({tag, "_code"},    code, e.code);
    check({tag, "_chk_cnt"}, chk,  e.chk);
    check({tag, "_err_cnt"}, err,  e.err);
    check({tag, "_run_cyc"}, run,  e.run);
    check({tag, "_latency"}, ncyc, e.cyc);
  endtask

  // ---------------- monitors ----------------
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always @(negedge clk) begin : mon_a
    exp_t e;
    check("a_exclusive", (pa && fa), 0);
    if ((pa || fa) && !prev_a) begin
      if (qa.size() == 0) check("a_unexpected_verdict", 1, 0);
      else begin
        e = qa.pop_front();
        cmp("a", e, pa, fa, codea, chka, erra, runa);
      end
    end
    prev_a <= pa || fa;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    check("b_exclusive", (pb && fb), 0);
    if ((pb || fb) && !prev_b) begin
      if (qb.size() == 0) check("b_unexpected_verdict", 1, 0);
      else begin
        e = qb.pop_front();
        cmp("b", e, pb, fb, codeb, chkb, errb, runb);
      end
    end
    prev_b <= pb || fb;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic st, input logic v, input logic [DW-1:0] a,
                       input logic [DW-1:0] e, input logic [DW-1:0] m, input logic d);
    @(negedge clk);
    start_i = st; chk_valid_i = v; act_i = a; exp_i = e; mask_i = m; done_i = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((qa.size() + qb.size()) != 0 && n < budget) begin
      idle();
      n++;
    end
    if ((qa.size() + qb.size()) != 0) begin
      check("verdict_wait_expired", qa.size() + qb.size(), 0);
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_passed"}, pa, 0);   check({tag, "_a_failed"}, fa, 0);
    check({tag, "_a_code"}, codea, 0);  check({tag, "_a_chk"}, chka, 0);
    check({tag, "_a_err"}, erra, 0);    check({tag, "_a_run"}, runa, 0);
    check({tag, "_b_passed"}, pb, 0);   check({tag, "_b_failed"}, fb, 0);
    check({tag, "_b_chk"}, chkb, 0);    check({tag, "_b_run"}, runb, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_i = 0; chk_valid_i = 0; act_i = '0; exp_i = '0; mask_i = '0; done_i = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    start_i = 0; chk_valid_i = 0; act_i = '0; exp_i = '0; mask_i = '0; done_i = 0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;

    // IDLE ignores checks and done
    drive(1'b0, 1'b1, 32'h1, 32'h2, '1, 1'b1);
    idle();
    check_zero("idle_ignore");

    // Clean pass: 3 matching checks then done
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 32'hA5, 32'hA5, '1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    qa.push_back(mk(1, 0, 0, 3, 0, 4));
    qb.push_back(mk(1, 0, 0, 3, 0, 4));
    wait_empty(10);
    // start/checks/done in PASS are ignored
    drive(1'b1, 1'b1, 32'h1, 32'h2, '1, 1'b1);
    idle(); idle();
    check("pass_sticky", pa, 1);
    check("pass_freeze_chk", chka, 3);
    check("pass_freeze_run", runa, 4);

    // Masked mismatch
    do_reset();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'h0F, 32'h00, 32'hF0, 1'b0);
    drive(1'b0, 1'b1, 32'h0F, 32'h00, 32'h01, 1'b0);
    qa.push_back(mk(0, 1, 1, 2, 1, 2));
    qb.push_back(mk(0, 1, 1, 2, 1, 2));
    wait_empty(10);
    drive(1'b0, 1'b1, 32'h0F, 32'h00, 32'h01, 1'b1);
    idle();
    check("fail_freeze_chk", chka, 2);
    check("fail_freeze_err", erra, 1);
    check("fail_freeze_run", runa, 2);
    check("fail_sticky_code", codea, 1);

    // One check then done: floor 1 passes, floor 2 underruns
    do_reset();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hA5, 32'hA5, '1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    qa.push_back(mk(1, 0, 0, 1, 0, 2));
    qb.push_back(mk(0, 1, 3, 1, 0, 2));
    wait_empty(10);

    // Check with zero mask arriving together with done counts toward floor
    do_reset();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'h55, 32'hAA, 32'h0, 1'b1);
    qa.push_back(mk(1, 0, 0, 1, 0, 1));
    qb.push_back(mk(0, 1, 3, 1, 0, 1));
    wait_empty(10);

    // Watchdog: 90th RUN cycle (run_cyc==89) decides
    do_reset();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    repeat (89) idle();
    idle();
    qa.push_back(mk(0, 1, 2, 0, 0, 90));
    qb.push_back(mk(0, 1, 2, 0, 0, 90));
    wait_empty(10);
    repeat (3) idle();
    check("timeout_freeze_run", runa, 90);

    // Mismatch with done in same cycle reports mismatch
    do_reset();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'h1, 32'h2, '1, 1'b1);
    qa.push_back(mk(0, 1, 1, 1, 1, 1));
    qb.push_back(mk(0, 1, 1, 1, 1, 1));
    wait_empty(10);

    // Asynchronous reset away from any clock edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // Fresh run after reset passes cleanly
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 32'h3C, 32'h3C, '1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    qa.push_back(mk(1, 0, 0, 2, 0, 3));
    qb.push_back(mk(1, 0, 0, 2, 0, 3));
    wait_empty(10);

`ifdef PFM_ERR_CAPTURE_EN
    // First-mismatch capture at run_cyc 4; later mismatch ignored
    do_reset();
    check("cap_reset_act", cap_act_a, 0);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
    repeat (4) idle();
    drive(1'b0, 1'b1, 32'h12, 32'h13, '1, 1'b0);
    qa.push_back(mk(0, 1, 1, 1, 1, 5));
    qb.push_back(mk(0, 1, 1, 1, 1, 5));
    idle();
    drive(1'b0, 1'b1, 32'h55, 32'h66, '1, 1'b0);
    wait_empty(10);
    check("cap_actual", cap_act_a, 32'h12);
    check("cap_expect", cap_exp_a, 32'h13);
    check("cap_cyc", cap_cyc_a, 4);
    repeat (5) idle();
    check("cap_hold_actual", cap_act_a, 32'h12);
    check("cap_hold_cyc", cap_cyc_a, 4);
`endif

    idle();
    check("queues_drained", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pass_fail_monitor
`default_nettype wire
